// File: rtl/seven_segment_scanner_if.sv
// Register bus between the CPU and the seven-segment scanner: one write port
// and one combinational read port.
interface seven_segment_scanner_if;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  rd_addr;
    logic [31:0] rd_data;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr,
        output rd_data
    );
endinterface

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode hex display controller: one shared decoder,
// per-digit dead time, and a frame-aligned shadow copy of the display registers.
module seven_segment_scanner #(
    parameter int NUM_DIGITS   = 8,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seven_segment_scanner_if.slave bus,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic                  frame_done
);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        DRIVE = 2'd1,
        BLANK = 2'd2
    } state_t;

    localparam int MAX_CNT = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [2:0]       LAST_IDX   = 3'(NUM_DIGITS - 1);
    localparam logic [31:0]      DIGIT_BITS = (NUM_DIGITS >= 8) ? 32'hFFFF_FFFF
                                              : ((32'd1 << (4 * NUM_DIGITS)) - 32'd1);

    logic [31:0] value_reg;
    logic [31:0] ctrl_reg;
    logic [7:0]  dp_reg;

    state_t           state, state_next;
    logic [2:0]       idx, idx_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [31:0]      shadow, shadow_next;
    logic [7:0]       shadow_dp, shadow_dp_next;
    logic [7:0]       shadow_mask, shadow_mask_next;
    logic             shadow_lzb, shadow_lzb_next;

    logic                  reload;
    logic                  frame_done_next;
    logic [31:0]           value_in, ctrl_in;
    logic [7:0]            dp_in;
    logic [3:0]            nibble;
    logic                  lz_blank;
    logic                  lit;
    logic [6:0]            seg_next;
    logic                  dp_next;
    logic [NUM_DIGITS-1:0] an_next;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_reg <= '0;
            ctrl_reg  <= '0;
            dp_reg    <= '0;
        end else if (bus.wr_en) begin
            case (bus.wr_addr)
                2'd0:    value_reg <= bus.wr_data;
                2'd1:    ctrl_reg  <= bus.wr_data;
                2'd2:    dp_reg    <= bus.wr_data[7:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.rd_data = '0;
        case (bus.rd_addr)
            2'd0:    bus.rd_data = value_reg;
            2'd1:    bus.rd_data = ctrl_reg;
            2'd2:    bus.rd_data = {24'd0, dp_reg};
            default: bus.rd_data = {27'd0, idx, state};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= OFF;
            idx         <= '0;
            cnt         <= '0;
            shadow      <= '0;
            shadow_dp   <= '0;
            shadow_mask <= '0;
            shadow_lzb  <= 1'b0;
            seg_n       <= 7'h7F;
            dp_n        <= 1'b1;
            an_n        <= '1;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            cnt         <= cnt_next;
            shadow      <= shadow_next;
            shadow_dp   <= shadow_dp_next;
            shadow_mask <= shadow_mask_next;
            shadow_lzb  <= shadow_lzb_next;
            seg_n       <= seg_next;
            dp_n        <= dp_next;
            an_n        <= an_next;
            frame_done  <= frame_done_next;
        end
    end

    always_comb begin
        state_next      = state;
        idx_next        = idx;
        cnt_next        = cnt;
        reload          = 1'b0;
        frame_done_next = 1'b0;

        case (state)
            OFF: begin
                if (ctrl_reg[0]) begin
                    state_next = DRIVE;
                    idx_next   = '0;
                    cnt_next   = '0;
                    reload     = 1'b1;
                end
            end
            DRIVE: begin
                if (cnt == DRIVE_LAST) begin
                    state_next = BLANK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_next = DRIVE;
                    cnt_next   = '0;
                    if (idx == LAST_IDX) begin
                        idx_next        = '0;
                        reload          = 1'b1;
                        frame_done_next = 1'b1;
                    end else begin
                        idx_next = idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = OFF;
        endcase

        if (!ctrl_reg[0]) begin
            state_next      = OFF;
            idx_next        = '0;
            cnt_next        = '0;
            reload          = 1'b0;
            frame_done_next = 1'b0;
        end

        // A register write landing on the reload edge goes straight into the shadow
        value_in = (bus.wr_en && bus.wr_addr == 2'd0) ? bus.wr_data : value_reg;
        ctrl_in  = (bus.wr_en && bus.wr_addr == 2'd1) ? bus.wr_data : ctrl_reg;
        dp_in    = (bus.wr_en && bus.wr_addr == 2'd2) ? bus.wr_data[7:0] : dp_reg;

        shadow_next      = reload ? value_in       : shadow;
        shadow_dp_next   = reload ? dp_in          : shadow_dp;
        shadow_mask_next = reload ? ctrl_in[15:8]  : shadow_mask;
        shadow_lzb_next  = reload ? ctrl_in[1]     : shadow_lzb;

        // A digit is a leading zero when it and every digit above it are zero
        nibble   = shadow_next[{idx_next, 2'b00} +: 4];
        lz_blank = shadow_lzb_next && (idx_next != 3'd0)
                   && (((shadow_next & DIGIT_BITS) >> {idx_next, 2'b00}) == 32'd0);
        lit      = shadow_mask_next[idx_next] && !lz_blank;

        seg_next = 7'h7F;
        dp_next  = 1'b1;
        an_next  = '1;
        if (state_next == DRIVE) begin
            seg_next = hex7(nibble);
            if (lit) begin
                dp_next = ~shadow_dp_next[idx_next];
                an_next = ~(NUM_DIGITS'(1) << idx_next);
            end
        end
    end

endmodule
